// File: rtl/hpu_cand_buffer.sv
// Candidate buffer feeding the HPU pivot tree: loads one batch, captures the tree winner, hands it out.
// Optional HPU_CBUF_ZERO_SKIP_EN: zero-valued beats are accepted but never stored.
module hpu_cand_buffer #(
  parameter int DATA_W    = 32,
  parameter int ROW_IDX_W = 16,
  parameter int MAX_ELEMS = 256,
  localparam int CNT_W    = $clog2(MAX_ELEMS) + 1,
  localparam int IDX_W    = $clog2(MAX_ELEMS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [DATA_W-1:0]    in_val,
  input  logic [ROW_IDX_W-1:0]        in_row,
  input  logic                        in_last,
  output logic signed [DATA_W-1:0]    cand_val [MAX_ELEMS],
  output logic [ROW_IDX_W-1:0]        cand_row [MAX_ELEMS],
  output logic [CNT_W-1:0]            num_elems,
  input  logic [ROW_IDX_W-1:0]        tree_row,
  input  logic signed [DATA_W-1:0]    tree_value,
  input  logic                        tree_valid,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [ROW_IDX_W-1:0]        out_row,
  output logic signed [DATA_W-1:0]    out_value,
  output logic                        out_found,
  output logic                        overflow
);

  typedef enum logic [1:0] {LOAD, SELECT, OUT} state_t;

  state_t state, state_nxt;
  logic   accept, full, skip, store, drop, release_out;

  assign in_ready    = (state == LOAD);
  assign out_valid   = (state == OUT);
  assign accept      = in_valid && in_ready;
  assign full        = (num_elems == CNT_W'(MAX_ELEMS));
  assign release_out = (state == OUT) && out_ready;

`ifdef HPU_CBUF_ZERO_SKIP_EN
  assign skip = (in_val == '0);
`else
  assign skip = 1'b0;
`endif

  // A skipped zero never counts as a drop, so it cannot raise overflow.
  assign store = accept && !full && !skip;
  assign drop  = accept && full && !skip;

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (accept && in_last) state_nxt = SELECT;
      SELECT:  state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= LOAD;
      num_elems <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (store)
        num_elems <= num_elems + CNT_W'(1);
      else if (release_out)
        num_elems <= '0;
      if (drop)
        overflow <= 1'b1;
      else if (release_out)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_ELEMS; i++) begin
        cand_val[i] <= '0;
        cand_row[i] <= '0;
      end
    end else if (store) begin
      cand_val[num_elems[IDX_W-1:0]] <= in_val;
      cand_row[num_elems[IDX_W-1:0]] <= in_row;
    end
  end

  // Winner is sampled at the single SELECT edge and held through OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_row   <= '0;
      out_value <= '0;
      out_found <= 1'b0;
    end else if (state == SELECT) begin
      out_row   <= tree_row;
      out_value <= tree_value;
      out_found <= tree_valid;
    end
  end

endmodule
